// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared constants and types for the 3x3 window fetcher
package window_pkg;

  localparam int WIDTH_DEF  = 80;
  localparam int HEIGHT_DEF = 60;
  localparam int ADDR_W_DEF = 13;

  // Byte slot of each window pixel inside the 72-bit window word
  localparam logic [3:0] B00 = 4'd0;
  localparam logic [3:0] B01 = 4'd1;
  localparam logic [3:0] B02 = 4'd2;
  localparam logic [3:0] B10 = 4'd3;
  localparam logic [3:0] B11 = 4'd4;
  localparam logic [3:0] B12 = 4'd5;
  localparam logic [3:0] B20 = 4'd6;
  localparam logic [3:0] B21 = 4'd7;
  localparam logic [3:0] B22 = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Travels alongside each read so the returning byte knows its slot
  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } tag_t;

endpackage

// File: rtl/window_scan_ctr.sv
// rtl/window_scan_ctr.sv - raster row/col/ref counters for the window scan
module window_scan_ctr
  import window_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] ref_addr,
  output logic [ADDR_W-1:0] ref_nxt,
  output logic [6:0]        row,
  output logic [6:0]        col,
  output logic              last
);

  localparam logic [6:0]        COL_LAST = 7'(WIDTH - 3);
  localparam logic [6:0]        ROW_LAST = 7'(HEIGHT - 3);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] ref_q, ref_d;
  logic [6:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic              wrap;

  // Next position: step one column, or skip the two edge columns onto the next row
  always_comb begin
    wrap    = (col_q == COL_LAST);
    ref_nxt = wrap ? ref_q + ADDR_W'(3) : ref_q + ADDR_W'(1);
    ref_d   = ref_q;
    row_d   = row_q;
    col_d   = col_q;
    if (clear) begin
      ref_d = BASE;
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      ref_d = ref_nxt;
      if (wrap) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= BASE;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ref_q <= ref_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign ref_addr = ref_q;
  assign row      = row_q;
  assign col      = col_q;
  assign last     = wrap && (row_q == ROW_LAST);

endmodule

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - reads 3x3 windows from RAM and presents them as 72-bit words
module window_fetch
  import window_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [6:0]        win_row,
  output logic [6:0]        win_col
);

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WIDTH - 2);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        rd_idx_q, rd_idx_d;
  logic [1:0]        rd_col_q, rd_col_d;
  logic [1:0]        drain_q, drain_d;
  logic              win_valid_q, win_valid_d;
  logic [6:0]        win_row_q, win_row_d, win_col_q, win_col_d;
  logic [71:0]       win_data_q, win_data_d;
  tag_t              tag_q [RD_LAT];
  tag_t              tag_d [RD_LAT];
  tag_t              tag_out;

  logic              accept, ctr_clear, ctr_advance, last;
  logic [ADDR_W-1:0] ref_addr, ref_nxt;
  logic [6:0]        row, col;

  window_scan_ctr #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) u_scan (
    .clk(clk), .rst_n(rst_n), .clear(ctr_clear), .advance(ctr_advance),
    .ref_addr(ref_addr), .ref_nxt(ref_nxt), .row(row), .col(col), .last(last)
  );

  // Scan sequencing and the read address walk (+1 within a row, +WIDTH-2 to the next row)
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    rd_idx_d    = rd_idx_q;
    rd_col_d    = rd_col_q;
    drain_d     = drain_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    ctr_clear   = 1'b0;
    ctr_advance = 1'b0;
    accept      = win_valid_q && win_ready;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ISSUE;
          busy_d     = 1'b1;
          ctr_clear  = 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = ref_addr;
          rd_idx_d   = B00;
          rd_col_d   = 2'd0;
        end
      end
      ST_ISSUE: begin
        if (rd_idx_q == B22) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else begin
          mem_rd_d = 1'b1;
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_col_q == 2'd2) begin
            rd_col_d   = 2'd0;
            mem_addr_d = mem_addr_q + ROW_STEP;
          end else begin
            rd_col_d   = rd_col_q + 2'd1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d     = ST_PRESENT;
          win_valid_d = 1'b1;
          win_row_d   = row;
          win_col_d   = col;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          win_valid_d = 1'b0;
          if (last) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            ctr_clear = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            ctr_advance = 1'b1;
            mem_rd_d    = 1'b1;
            mem_addr_d  = ref_nxt;
            rd_idx_d    = B00;
            rd_col_d    = 2'd0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_idx_q    <= '0;
      rd_col_q    <= '0;
      drain_q     <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rd_idx_q    <= rd_idx_d;
      rd_col_q    <= rd_col_d;
      drain_q     <= drain_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Tag pipe matches RAM latency; the exiting tag steers mem_data into its byte slot
  always_comb begin
    tag_d[0] = '{vld: mem_rd_q, idx: rd_idx_q};
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    tag_out    = tag_q[RD_LAT-1];
    win_data_d = win_data_q;
    if (tag_out.vld) win_data_d[{tag_out.idx, 3'b000} +: 8] = mem_data;
  end

  // Tag pipe and window data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      win_data_q <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
      win_data_q <= win_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - self-checking bench for window_fetch at RD_LAT 1 and 3
`timescale 1ns/1ps
module tb_window_fetch;

  localparam int W     = 80;
  localparam int H     = 60;
  localparam int AW    = 13;
  localparam int TOTAL = (W - 2) * (H - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s [2];
  logic          start_s [2];
  logic          win_ready_s [2];
  logic          busy_s [2];
  logic          done_s [2];
  logic          mem_rd_s [2];
  logic          win_valid_s [2];
  logic [AW-1:0] mem_addr_s [2];
  logic [7:0]    mem_data_s [2];
  logic [71:0]   win_data_s [2];
  logic [6:0]    win_row_s [2];
  logic [6:0]    win_col_s [2];

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] pipe [LAT];
    always @(posedge clk) begin
      if (mem_rd_s[g] === 1'b1) pipe[0] <= mem_addr_s[g][7:0];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_s[g] = pipe[LAT-1];

    window_fetch #(
      .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst_n(rst_s[g]), .start(start_s[g]), .busy(busy_s[g]), .done(done_s[g]),
      .mem_rd(mem_rd_s[g]), .mem_addr(mem_addr_s[g]), .mem_data(mem_data_s[g]),
      .win_valid(win_valid_s[g]), .win_ready(win_ready_s[g]), .win_data(win_data_s[g]),
      .win_row(win_row_s[g]), .win_col(win_col_s[g])
    );
  end

  typedef struct {
    int          n;
    int          row;
    int          col;
    int          first_addr;
    logic [71:0] data;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: window n sits at (n / (W-2), n % (W-2)); read j covers pixel (j/3, j%3)
  function automatic logic [AW-1:0] model_addr(input int n, input int j);
    int row, col;
    row = n / (W - 2);
    col = n % (W - 2);
    return AW'((row + j / 3) * W + col + j % 3);
  endfunction

  function automatic logic [71:0] model_win(input int n);
    logic [71:0]   w;
    logic [AW-1:0] a;
    w = '0;
    for (int j = 0; j < 9; j++) begin
      a = model_addr(n, j);
      w[8*j +: 8] = a[7:0];
    end
    return w;
  endfunction

  int          wcnt [2];
  int          rdcnt [2];
  int          rd_total [2];
  int          done_cnt [2];
  int          frame_n [2];
  logic        pvalid [2];
  logic [71:0] pdata [2];
  logic [6:0]  prow [2];
  logic [6:0]  pcol [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      wcnt[k] = 0; rdcnt[k] = 0; rd_total[k] = 0; done_cnt[k] = 0; frame_n[k] = 0;
      pvalid[k] = 1'b0; pdata[k] = '0; prow[k] = '0; pcol[k] = '0;
    end
  end

  // Monitor: every read address, every accepted window and every stall against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_s[k] !== 1'b1) begin
        wcnt[k] = 0; rdcnt[k] = 0; pvalid[k] = 1'b0;
      end else begin
        if (mem_rd_s[k]) begin
          chk("rd_addr", mem_addr_s[k], model_addr(wcnt[k], rdcnt[k]));
          chk("rd_while_valid", win_valid_s[k], 1'b0);
          for (int i = 0; i < 5; i++)
            if (rdcnt[k] == 0 && tbl[i].n == wcnt[k])
              chk("tbl_first_addr", mem_addr_s[k], tbl[i].first_addr);
          rdcnt[k]++;
          rd_total[k]++;
        end
        if (win_valid_s[k] && pvalid[k]) begin
          chk("hold_data", win_data_s[k], pdata[k]);
          chk("hold_row", win_row_s[k], prow[k]);
          chk("hold_col", win_col_s[k], pcol[k]);
        end
        if (win_valid_s[k] && win_ready_s[k]) begin
          chk("win_data", win_data_s[k], model_win(wcnt[k]));
          chk("win_row", win_row_s[k], wcnt[k] / (W - 2));
          chk("win_col", win_col_s[k], wcnt[k] % (W - 2));
          chk("reads_per_win", rdcnt[k], 9);
          for (int i = 0; i < 5; i++)
            if (tbl[i].n == wcnt[k]) begin
              chk("tbl_row", win_row_s[k], tbl[i].row);
              chk("tbl_col", win_col_s[k], tbl[i].col);
              chk("tbl_data", win_data_s[k], tbl[i].data);
            end
          wcnt[k]++;
          rdcnt[k] = 0;
        end
        pvalid[k] = win_valid_s[k] && !win_ready_s[k];
        pdata[k]  = win_data_s[k];
        prow[k]   = win_row_s[k];
        pcol[k]   = win_col_s[k];
        if (done_s[k]) begin
          done_cnt[k]++;
          frame_n[k] = wcnt[k];
          wcnt[k]    = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int k, input string name);
    chk({name, "_busy"}, busy_s[k], 1'b0);
    chk({name, "_done"}, done_s[k], 1'b0);
    chk({name, "_mem_rd"}, mem_rd_s[k], 1'b0);
    chk({name, "_mem_addr"}, mem_addr_s[k], 0);
    chk({name, "_win_valid"}, win_valid_s[k], 1'b0);
    chk({name, "_win_data"}, win_data_s[k], 0);
    chk({name, "_win_row"}, win_row_s[k], 0);
    chk({name, "_win_col"}, win_col_s[k], 0);
  endtask

  task automatic do_reset(input int k);
    rst_s[k] = 1'b0; start_s[k] = 1'b0; win_ready_s[k] = 1'b0;
    tick; tick;
    check_zero(k, "reset");
    rst_s[k] = 1'b1;
    tick;
  endtask

  task automatic first_window(input int k, input int lat);
    int c;
    start_s[k] = 1'b1; tick; start_s[k] = 1'b0;
    chk("fw_busy", busy_s[k], 1'b1);
    chk("fw_rd", mem_rd_s[k], 1'b1);
    chk("fw_addr0", mem_addr_s[k], 0);
    c = 0;
    while (!win_valid_s[k] && c < 100) begin tick; c++; end
    chk("fw_latency", c, 9 + lat);
    chk("fw_row", win_row_s[k], 0);
    chk("fw_col", win_col_s[k], 0);
    chk("fw_data", win_data_s[k], 72'hA2A1A0_525150_020100);
  endtask

  task automatic run_windows(input int k, input int nwin, input int maxcyc);
    int target, c;
    target = wcnt[k] + nwin;
    c = 0;
    while (wcnt[k] < target && c < maxcyc) begin
      win_ready_s[k] = ($urandom_range(0, 2) != 0);
      start_s[k]     = ($urandom_range(0, 15) == 0);
      tick; c++;
    end
    start_s[k] = 1'b0; win_ready_s[k] = 1'b0;
    chk("run_progress", wcnt[k] >= target, 1'b1);
  endtask

  int cyc, snap;

  initial begin
    tbl[0] = '{0,    0,  0,  0,    72'hA2A1A0_525150_020100};
    tbl[1] = '{1,    0,  1,  1,    72'hA3A2A1_535251_030201};
    tbl[2] = '{77,   0,  77, 77,   72'hEFEEED_9F9E9D_4F4E4D};
    tbl[3] = '{78,   1,  0,  80,   72'hF2F1F0_A2A1A0_525150};
    tbl[4] = '{4523, 57, 77, 4637, 72'hBFBEBD_6F6E6D_1F1E1D};
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b0; start_s[k] = 1'b0; win_ready_s[k] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    // First window, then a 20-cycle stall, then the next window's reads from ref=1
    first_window(0, 1);
    repeat (20) begin
      tick;
      chk("stall_valid", win_valid_s[0], 1'b1);
      chk("stall_no_rd", mem_rd_s[0], 1'b0);
    end
    chk("stall_data", win_data_s[0], 72'hA2A1A0_525150_020100);
    win_ready_s[0] = 1'b1; tick; win_ready_s[0] = 1'b0;
    chk("acc_valid_drop", win_valid_s[0], 1'b0);
    chk("acc_next_rd", mem_rd_s[0], 1'b1);
    chk("acc_next_addr", mem_addr_s[0], 1);

    // Random back-pressure and stray start pulses across the row wrap, then the rest of the frame
    run_windows(0, 100, 6000);
    chk("mid_busy", busy_s[0], 1'b1);
    win_ready_s[0] = 1'b1;
    cyc = 0;
    while (!done_s[0] && cyc < 70000) begin tick; cyc++; end
    chk("done_seen", done_s[0], 1'b1);
    chk("busy_low_in_done", busy_s[0], 1'b0);
    start_s[0] = 1'b1; tick; start_s[0] = 1'b0;
    win_ready_s[0] = 1'b0;
    chk("frame_windows", frame_n[0], TOTAL);
    snap = rd_total[0];
    repeat (5) tick;
    chk("done_start_ignored_busy", busy_s[0], 1'b0);
    chk("done_start_ignored_rd", rd_total[0], snap);
    chk("done_low", done_s[0], 1'b0);
    chk("done_once", done_cnt[0], 1);

    // Abort mid-ISSUE, then restart from window (0,0)
    start_s[0] = 1'b1; tick; start_s[0] = 1'b0;
    repeat (4) tick;
    chk("abort_in_issue", mem_rd_s[0], 1'b1);
    #2 rst_s[0] = 1'b0;
    #1 check_zero(0, "abort");
    tick; rst_s[0] = 1'b1; tick;
    first_window(0, 1);
    run_windows(0, 20, 2000);
    chk("abort_no_done", done_cnt[0], 1);

    // Same first-window checks at RD_LAT=3, plus some random traffic
    first_window(1, 3);
    run_windows(1, 30, 3000);
    chk("lat3_no_done", done_cnt[1], 0);
    do_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
